game_over_overlay: RTL and testbench

Downstream compositing stage for the game-over sprite. Takes the sprite stage's palette RGB and `gameoveron` window flag plus the playfield background RGB, and produces the final VGA colour. A frame-synchronous state machine fades the sprite in when the game ends, holds it, optionally blinks it, and fades it out on restart. Sits between the sprite/background pixel generators and the VGA output pins.

---
 rtl/game_over_pkg.sv | 16 +
 rtl/rgb_blend.sv | 26 ++
 rtl/game_over_overlay.sv | 190 +++++++++++++++++++
 tb/tb_game_over_overlay.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_over_pkg.sv
// Shared types and constants for the game-over overlay compositing stage.
package game_over_pkg;

  localparam int unsigned COLOR_W   = 4;
  localparam int unsigned ALPHA_W   = 5;
  localparam int unsigned ALPHA_MAX = 16;

  typedef enum logic [2:0] {
    IDLE,
    FADE_IN,
    SHOW,
    WAIT,
    FADE_OUT
  } go_state_t;

endpackage

// File: rtl/rgb_blend.sv
// Single-channel alpha blend: (sprite*a + bg*(16-a)) >> 4, truncated to colour width.
module rgb_blend
  import game_over_pkg::*;
(
  input  logic [COLOR_W-1:0] sprite,
  input  logic [COLOR_W-1:0] bg,
  input  logic [ALPHA_W-1:0] alpha,
  output logic [COLOR_W-1:0] color
);

  localparam int unsigned PROD_W = 2 * COLOR_W;

  logic [ALPHA_W-1:0] alpha_inv;
  logic [PROD_W-1:0]  prod_sprite;
  logic [PROD_W-1:0]  prod_bg;
  logic [PROD_W:0]    sum;

  always_comb begin
    alpha_inv   = ALPHA_W'(ALPHA_MAX) - alpha;
    prod_sprite = PROD_W'(sprite) * PROD_W'(alpha);
    prod_bg     = PROD_W'(bg) * PROD_W'(alpha_inv);
    sum         = (PROD_W + 1)'(prod_sprite) + (PROD_W + 1)'(prod_bg);
    color       = COLOR_W'(sum >> 4);
  end

endmodule

// File: rtl/game_over_overlay.sv
// Game-over sprite compositor: frame-synchronous fade-in/hold/fade-out over the background.
// Optional blink in SHOW/WAIT is built when GAME_OVER_BLINK_EN is defined.
module game_over_overlay
  import game_over_pkg::*;
#(
  parameter int unsigned FADE_STEP_FRAMES = 2,
  parameter int unsigned HOLD_FRAMES      = 120,
  parameter int unsigned BLINK_FRAMES     = 30
) (
  input  logic               vga_clk,
  input  logic               Reset,
  input  logic               vsync,
  input  logic               blank,
  input  logic               game_over,
  input  logic               restart,
  input  logic               gameoveron,
  input  logic [COLOR_W-1:0] sprite_red,
  input  logic [COLOR_W-1:0] sprite_green,
  input  logic [COLOR_W-1:0] sprite_blue,
  input  logic [COLOR_W-1:0] bg_red,
  input  logic [COLOR_W-1:0] bg_green,
  input  logic [COLOR_W-1:0] bg_blue,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               overlay_active,
  output logic               ready_restart
);

  localparam int unsigned STEP_W = $clog2(FADE_STEP_FRAMES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [ALPHA_W-1:0] A_MAX    = ALPHA_W'(ALPHA_MAX);
  localparam logic [ALPHA_W-1:0] A_MAX_M1 = ALPHA_W'(ALPHA_MAX - 1);
  localparam logic [ALPHA_W-1:0] A_ONE    = ALPHA_W'(1);

  if (FADE_STEP_FRAMES == 0 || HOLD_FRAMES == 0 || BLINK_FRAMES == 0) begin : g_param_check
    $error("game_over_overlay: frame-count parameters must be at least 1");
  end

  go_state_t          state;
  go_state_t          state_next;
  logic               entering;
  logic               vsync_q;
  logic               tick;
  logic               step_fire;
  logic               hold_done;
  logic [ALPHA_W-1:0] alpha;
  logic [ALPHA_W-1:0] alpha_eff;
  logic [STEP_W-1:0]  step_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               overlay_d;
  logic               ready_d;
  logic               on_d;
  logic [COLOR_W-1:0] blend_r;
  logic [COLOR_W-1:0] blend_g;
  logic [COLOR_W-1:0] blend_b;

  always_comb begin
    tick      = vsync_q & ~vsync;
    step_fire = tick && (step_cnt == STEP_W'(FADE_STEP_FRAMES - 1));
    hold_done = tick && (hold_cnt == HOLD_W'(HOLD_FRAMES - 1));
  end

  // State register, with the Moore flags registered alongside it.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state          <= IDLE;
      vsync_q        <= 1'b1;
      overlay_active <= 1'b0;
      ready_restart  <= 1'b0;
    end else begin
      state          <= state_next;
      vsync_q        <= vsync;
      overlay_active <= overlay_d;
      ready_restart  <= ready_d;
    end
  end

  // Restart beats a simultaneous game_over in WAIT; game_over beats completion in FADE_OUT.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (game_over) state_next = FADE_IN;
      FADE_IN:  if (alpha == A_MAX || (step_fire && alpha == A_MAX_M1)) state_next = SHOW;
      SHOW:     if (hold_done) state_next = WAIT;
      WAIT:     if (restart) state_next = FADE_OUT;
      FADE_OUT: begin
        if (game_over) state_next = FADE_IN;
        else if (alpha == '0 || (step_fire && alpha == A_ONE)) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    entering  = (state_next != state);
    overlay_d = (state_next != IDLE);
    ready_d   = (state_next == WAIT);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      alpha    <= '0;
      step_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE:     alpha <= '0;
        FADE_IN:  if (step_fire && alpha != A_MAX) alpha <= alpha + A_ONE;
        FADE_OUT: if (!game_over && step_fire && alpha != '0) alpha <= alpha - A_ONE;
        default:  alpha <= alpha;
      endcase

      if (entering)
        step_cnt <= '0;
      else if (tick && (state == FADE_IN || state == FADE_OUT))
        step_cnt <= step_fire ? '0 : step_cnt + STEP_W'(1);

      if (entering)
        hold_cnt <= '0;
      else if (tick && state == SHOW)
        hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

`ifdef GAME_OVER_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               blink_toggle;

  always_comb begin
    blink_toggle = tick && (state == SHOW || state == WAIT)
                   && (blink_cnt == BLINK_W'(BLINK_FRAMES - 1));
    alpha_eff    = blink_phase ? '0 : alpha;
  end

  // Phase survives SHOW->WAIT (a toggle on that same tick still lands); any other entry clears it.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (entering)
        blink_cnt <= '0;
      else if (tick && (state == SHOW || state == WAIT))
        blink_cnt <= blink_toggle ? '0 : blink_cnt + BLINK_W'(1);

      if (entering && state_next != WAIT)
        blink_phase <= 1'b0;
      else if (blink_toggle)
        blink_phase <= ~blink_phase;
    end
  end
`else
  always_comb alpha_eff = alpha;
`endif

  rgb_blend u_blend_r (.sprite(sprite_red),   .bg(bg_red),   .alpha(alpha_eff), .color(blend_r));
  rgb_blend u_blend_g (.sprite(sprite_green), .bg(bg_green), .alpha(alpha_eff), .color(blend_g));
  rgb_blend u_blend_b (.sprite(sprite_blue),  .bg(bg_blue),  .alpha(alpha_eff), .color(blend_b));

  // on_d lines the window flag up with the colour inputs, which trail it by one clock.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      on_d  <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      on_d <= gameoveron;
      if (!blank) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else if (!on_d) begin
        red   <= bg_red;
        green <= bg_green;
        blue  <= bg_blue;
      end else begin
        red   <= blend_r;
        green <= blend_g;
        blue  <= blend_b;
      end
    end
  end

endmodule

// File: tb/tb_game_over_overlay.sv
// Self-checking bench for game_over_overlay: directed scenario plus randomized pixels/controls vs a behavioural model.
module tb_game_over_overlay;

  localparam int FADE = 2;
  localparam int HOLD = 120;
  localparam int BLK  = 30;
`ifdef GAME_OVER_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_IN = 1, M_SHOW = 2, M_WAIT = 3, M_OUT = 4;

  logic       vga_clk = 1'b0;
  logic       Reset, vsync, blank, game_over, restart, gameoveron;
  logic [3:0] sprite_red, sprite_green, sprite_blue, bg_red, bg_green, bg_blue;
  logic [3:0] red, green, blue;
  logic       overlay_active, ready_restart;

  game_over_overlay #(
    .FADE_STEP_FRAMES(FADE),
    .HOLD_FRAMES(HOLD),
    .BLINK_FRAMES(BLK)
  ) dut (
    .vga_clk(vga_clk), .Reset(Reset), .vsync(vsync), .blank(blank),
    .game_over(game_over), .restart(restart), .gameoveron(gameoveron),
    .sprite_red(sprite_red), .sprite_green(sprite_green), .sprite_blue(sprite_blue),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .red(red), .green(green), .blue(blue),
    .overlay_active(overlay_active), .ready_restart(ready_restart)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int fcnt = 0;
  bit rnd = 1'b0;

  // Behavioural reference: mode, alpha, ticks since entering the mode, blink phase.
  int m_mode = M_IDLE, m_alpha = 0, m_t = 0, m_phase = 0;
  bit m_vsq = 1'b1, m_ond = 1'b0, edge_tick = 1'b0;
  int exp_r = 0, exp_g = 0, exp_b = 0, exp_ovl = 0, exp_rdy = 0;

  function automatic int blend(input int s, input int b, input int a);
    return (s * a + b * (16 - a)) / 16;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge();
    int ea;
    int nm;
    bit tk;
    if (Reset) begin
      exp_r = 0; exp_g = 0; exp_b = 0; exp_ovl = 0; exp_rdy = 0;
      m_mode = M_IDLE; m_alpha = 0; m_t = 0; m_phase = 0;
      m_vsq = 1'b1; m_ond = 1'b0; edge_tick = 1'b0;
    end else begin
      ea = (m_phase != 0) ? 0 : m_alpha;
      if (!blank) begin
        exp_r = 0; exp_g = 0; exp_b = 0;
      end else if (!m_ond) begin
        exp_r = int'(bg_red); exp_g = int'(bg_green); exp_b = int'(bg_blue);
      end else begin
        exp_r = blend(int'(sprite_red),   int'(bg_red),   ea);
        exp_g = blend(int'(sprite_green), int'(bg_green), ea);
        exp_b = blend(int'(sprite_blue),  int'(bg_blue),  ea);
      end
      m_ond = gameoveron;
      tk = m_vsq && !vsync;
      m_vsq = vsync;
      edge_tick = tk;
      nm = m_mode;
      case (m_mode)
        M_IDLE: if (game_over) nm = M_IN;
        M_IN: begin
          if (m_alpha == 16) nm = M_SHOW;
          else if (tk) begin
            m_t++;
            if (m_t % FADE == 0) m_alpha++;
            if (m_alpha == 16) nm = M_SHOW;
          end
        end
        M_SHOW: if (tk) begin
          m_t++;
          if (BLINK_ON && m_t % BLK == 0) m_phase = 1 - m_phase;
          if (m_t == HOLD) nm = M_WAIT;
        end
        M_WAIT: begin
          if (tk) begin
            m_t++;
            if (BLINK_ON && m_t % BLK == 0) m_phase = 1 - m_phase;
          end
          if (restart) nm = M_OUT;
        end
        default: begin
          if (game_over) nm = M_IN;
          else if (m_alpha == 0) nm = M_IDLE;
          else if (tk) begin
            m_t++;
            if (m_t % FADE == 0) m_alpha--;
            if (m_alpha == 0) nm = M_IDLE;
          end
        end
      endcase
      if (nm != m_mode) begin
        m_t = 0;
        if (nm != M_WAIT) m_phase = 0;
      end
      m_mode = nm;
      exp_ovl = (nm != M_IDLE) ? 1 : 0;
      exp_rdy = (nm == M_WAIT) ? 1 : 0;
    end
  endtask

  task automatic cyc();
    if (rnd) begin
      gameoveron   = 1'($urandom);
      sprite_red   = 4'($urandom); sprite_green = 4'($urandom); sprite_blue = 4'($urandom);
      bg_red       = 4'($urandom); bg_green     = 4'($urandom); bg_blue     = 4'($urandom);
      blank        = ($urandom_range(7) != 0);
    end
    vsync = (fcnt < 2) ? 1'b0 : 1'b1;
    fcnt  = (fcnt + 1) % 6;
    @(posedge vga_clk);
    model_edge();
    if (edge_tick) tick_cnt++;
    #1;
    chk("red",   8'(red),            8'(exp_r));
    chk("green", 8'(green),          8'(exp_g));
    chk("blue",  8'(blue),           8'(exp_b));
    chk("ovl",   8'(overlay_active), 8'(exp_ovl));
    chk("rdy",   8'(ready_restart),  8'(exp_rdy));
  endtask

  task automatic wait_ticks(input int n);
    int budget;
    budget = 0;
    while (tick_cnt < n && budget < 3000) begin
      cyc();
      budget++;
    end
    chk("tick_timeout", 8'(tick_cnt >= n), 8'd1);
  endtask

  task automatic set_px(input logic [3:0] s, input logic [3:0] b, input logic on);
    sprite_red = s; sprite_green = s; sprite_blue = s;
    bg_red = b; bg_green = b; bg_blue = b;
    gameoveron = on;
    blank = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; vsync = 1'b1; game_over = 1'b0; restart = 1'b0;
    set_px(4'h0, 4'h0, 1'b0);
    repeat (3) cyc();
    chk("rst_red", 8'(red), 8'h0);
    chk("rst_ovl", 8'(overlay_active), 8'h0);
    chk("rst_rdy", 8'(ready_restart), 8'h0);
    Reset = 1'b0;

    // Background pass-through and blanking.
    set_px(4'hF, 4'h5, 1'b0);
    cyc(); cyc();
    chk("pass_bg", 8'(red), 8'h5);
    blank = 1'b0;
    cyc();
    chk("blank_zero", 8'(green), 8'h0);

    // Fade-in from game_over.
    set_px(4'hF, 4'h0, 1'b1);
    game_over = 1'b1;
    cyc();
    tick_cnt = 0;
    wait_ticks(2);  cyc(); chk("alpha1", 8'(red), 8'h0);
    chk("fade_ovl", 8'(overlay_active), 8'h1);
    wait_ticks(16); cyc(); chk("alpha8", 8'(red), 8'h7);
    wait_ticks(32);
    tick_cnt = 0;
    cyc(); chk("alpha16", 8'(blue), 8'hF);

    // SHOW ignores restart; WAIT after HOLD ticks; restart wins over game_over.
    restart = 1'b1; cyc(); cyc(); restart = 1'b0;
    chk("show_ign_rst", 8'(ready_restart), 8'h0);
    chk("show_ovl", 8'(overlay_active), 8'h1);
    wait_ticks(40); cyc();
    chk("blink40", 8'(red), BLINK_ON ? 8'h0 : 8'hF);
    wait_ticks(HOLD - 1);
    chk("hold_early", 8'(ready_restart), 8'h0);
    wait_ticks(HOLD);
    chk("hold_done", 8'(ready_restart), 8'h1);
    restart = 1'b1; cyc(); restart = 1'b0; game_over = 1'b0;
    chk("restart_wins", 8'(ready_restart), 8'h0);
    tick_cnt = 0;
    wait_ticks(31);
    chk("fadeout_31", 8'(overlay_active), 8'h1);
    wait_ticks(32);
    chk("fadeout_idle", 8'(overlay_active), 8'h0);

    // Fade-out interrupted at alpha 6 resumes fade-in.
    game_over = 1'b1; cyc(); tick_cnt = 0;
    wait_ticks(32); tick_cnt = 0;
    wait_ticks(HOLD);
    restart = 1'b1; cyc(); restart = 1'b0; game_over = 1'b0;
    tick_cnt = 0;
    wait_ticks(20);
    game_over = 1'b1; cyc(); tick_cnt = 0;
    cyc(); chk("resume_a6", 8'(red), 8'h5);
    wait_ticks(19); cyc(); chk("resume_a15", 8'(red), 8'hE);
    wait_ticks(20);
    chk("resume_show", 8'(overlay_active), 8'h1);
    cyc(); chk("resume_a16", 8'(green), 8'hF);

    // Reset mid-fade at alpha 9.
    Reset = 1'b1; cyc(); Reset = 1'b0;
    cyc(); tick_cnt = 0;
    wait_ticks(18);
    Reset = 1'b1; cyc();
    chk("midrst_red", 8'(red), 8'h0);
    chk("midrst_ovl", 8'(overlay_active), 8'h0);
    Reset = 1'b0; game_over = 1'b0;
    set_px(4'hF, 4'h3, 1'b1);
    cyc(); cyc();
    chk("midrst_bg", 8'(red), 8'h3);

    // Randomized pixels and controls.
    rnd = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) game_over = ~game_over;
      restart = ($urandom_range(15) == 0);
      Reset   = ($urandom_range(799) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
